// File: rtl/tff_pkg.sv
// Shared constants for the T flip-flop counter: direction encoding and default width.
package tff_pkg;

   localparam int unsigned DEFAULT_WIDTH = 4;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

endpackage : tff_pkg

// File: rtl/tff_cell.sv
// One-bit T flip-flop: toggles on a rising clk edge while t is high; async active-high clear.
module tff_cell (
   input  logic clk,
   input  logic rst,
   input  logic t,
   output logic q
);

   logic r_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q <= 1'b0;
      end else if (t) begin
         r_q <= ~r_q;
      end
   end

   assign q = r_q;

endmodule : tff_cell

// File: rtl/tff_counter.sv
// Up/down modulo-(MAX_COUNT+1) counter built from T flip-flop cells driven by toggle terms.
// Define TFF_COUNTER_SATURATE_EN to hold at the limits instead of wrapping.
module tff_counter
   import tff_pkg::*;
#(
   parameter int unsigned WIDTH     = DEFAULT_WIDTH,
   parameter int unsigned MAX_COUNT = (1 << WIDTH) - 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             load,
   input  logic             up,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             tc
);

   localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_COUNT);

   logic [WIDTH-1:0] w_t;
   logic [WIDTH-1:0] w_inc_t;
   logic [WIDTH-1:0] w_dec_t;
   logic [WIDTH-1:0] w_load_val;
   logic             w_at_max;
   logic             w_at_zero;

   assign w_at_max   = (q == MAX_Q);
   assign w_at_zero  = (q == '0);
   assign w_load_val = (d > MAX_Q) ? MAX_Q : d;

   // Bit i toggles on increment when all lower bits are 1, on decrement when all are 0.
   always_comb begin : toggle_terms
      logic v_carry;
      logic v_borrow;
      v_carry  = 1'b1;
      v_borrow = 1'b1;
      w_inc_t  = '0;
      w_dec_t  = '0;
      for (int i = 0; i < WIDTH; i++) begin
         w_inc_t[i] = v_carry;
         w_dec_t[i] = v_borrow;
         v_carry    = v_carry & q[i];
         v_borrow   = v_borrow & ~q[i];
      end
   end

   // Priority: load, then count, then hold; every case expressed as a per-bit toggle mask.
   always_comb begin : next_toggle
      w_t = '0;
      if (load) begin
         w_t = q ^ w_load_val;
      end else if (enable) begin
         if (up == DIR_UP) begin
            if (w_at_max) begin
`ifdef TFF_COUNTER_SATURATE_EN
               w_t = '0;
`else
               w_t = q;
`endif
            end else begin
               w_t = w_inc_t;
            end
         end else begin
            if (w_at_zero) begin
`ifdef TFF_COUNTER_SATURATE_EN
               w_t = '0;
`else
               w_t = q ^ MAX_Q;
`endif
            end else begin
               w_t = w_dec_t;
            end
         end
      end
   end

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      tff_cell u_cell (
         .clk (clk),
         .rst (rst),
         .t   (w_t[gi]),
         .q   (q[gi])
      );
   end

   assign tc = enable & (((up == DIR_UP) & w_at_max) | ((up == DIR_DOWN) & w_at_zero));

endmodule : tff_counter

// File: tb/tb_tff_counter.sv
// Directed bench for tff_counter (WIDTH=4, MAX_COUNT=9) with a queue scoreboard of expected q.
module tb_tff_counter;

   localparam int unsigned W   = 4;
   localparam int unsigned MAXC = 9;

   logic         clk = 1'b0;
   logic         rst;
   logic         enable;
   logic         load;
   logic         up;
   logic [W-1:0] d;
   logic [W-1:0] q;
   logic         tc;

   int vectors = 0;
   int errors  = 0;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] mq;

   tff_counter #(.WIDTH(W), .MAX_COUNT(MAXC)) dut (
      .clk    (clk),
      .rst    (rst),
      .enable (enable),
      .load   (load),
      .up     (up),
      .d      (d),
      .q      (q),
      .tc     (tc)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "timeout");
   end

   function automatic logic [W-1:0] model(input logic [W-1:0] cur, input logic en,
                                          input logic ld, input logic u, input logic [W-1:0] dv);
      logic [W-1:0] r;
      r = cur;
      if (ld) begin
         r = (dv > W'(MAXC)) ? W'(MAXC) : dv;
      end else if (en) begin
         if (u) begin
`ifdef TFF_COUNTER_SATURATE_EN
            r = (cur == W'(MAXC)) ? W'(MAXC) : cur + W'(1);
`else
            r = (cur == W'(MAXC)) ? W'(0) : cur + W'(1);
`endif
         end else begin
`ifdef TFF_COUNTER_SATURATE_EN
            r = (cur == W'(0)) ? W'(0) : cur - W'(1);
`else
            r = (cur == W'(0)) ? W'(MAXC) : cur - W'(1);
`endif
         end
      end
      return r;
   endfunction

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] expv);
      vectors++;
      assert (got === expv) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, expv);
      end
   endtask

   // Drive one cycle's controls just after an edge, check tc before the next edge, q after it.
   task automatic step(input logic en, input logic ld, input logic u, input logic [W-1:0] dv,
                       input string tag);
      logic exp_tc;
      enable = en; load = ld; up = u; d = dv;
      exp_tc = en & ((u & (mq == W'(MAXC))) | (~u & (mq == W'(0))));
      exp_q.push_back(model(mq, en, ld, u, dv));
      #1;
      check({tag, "_tc"}, 8'(tc), 8'(exp_tc));
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         check({tag, "_sb_empty"}, 8'(1), 8'(0));
      end else begin
         mq = exp_q.pop_front();
         check({tag, "_q"}, 8'(q), 8'(mq));
      end
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; load = 1'b0; up = 1'b1; d = '0;
      mq = '0;
      #1;
      check("reset_q", 8'(q), 8'(0));
      check("reset_tc_idle", 8'(tc), 8'(0));

      // Load and enable are ignored while reset is held; tc sees q=0 counting down.
      enable = 1'b1; load = 1'b1; up = 1'b0; d = 4'd5;
      #1;
      check("reset_tc_down", 8'(tc), 8'(1));
      @(posedge clk); #1;
      check("reset_hold_q", 8'(q), 8'(0));
      rst = 1'b0; enable = 1'b0; load = 1'b0; up = 1'b1;

      // Count up 12 edges from 0: 1..9,0,1,2.
      for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b1, '0, "up_wrap");

      // Count down 4 edges from 2: 1,0,9,8.
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, '0, "down_wrap");

      // Load clamps above MAX_COUNT, passes in-range values.
      step(1'b1, 1'b1, 1'b1, 4'hC, "load_clamp");
      step(1'b1, 1'b1, 1'b0, 4'd3, "load_3");

      // Hold at 7 for 5 edges, then one enabled edge.
      step(1'b0, 1'b1, 1'b0, 4'd7, "load_7");
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, '0, "hold");
      step(1'b1, 1'b0, 1'b1, '0, "resume");

      // Limits: up from 8 for 3 edges, down from 1 for 3 edges.
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, '0, "limit_up");
      step(1'b0, 1'b1, 1'b1, 4'd1, "load_1");
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, '0, "limit_down");

      // Direction flip every edge takes effect immediately.
      step(1'b1, 1'b1, 1'b1, 4'd4, "load_4");
      step(1'b1, 1'b0, 1'b1, '0, "flip_up");
      step(1'b1, 1'b0, 1'b0, '0, "flip_down");
      step(1'b1, 1'b0, 1'b0, '0, "flip_down2");
      step(1'b1, 1'b0, 1'b1, '0, "flip_up2");

      // Short mid-cycle reset pulse at q=5 clears without a clock edge.
      step(1'b0, 1'b1, 1'b1, 4'd5, "load_5");
      enable = 1'b0; load = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check("pulse_rst_q", 8'(q), 8'(0));
      rst = 1'b0;
      #1;
      check("pulse_after_q", 8'(q), 8'(0));
      mq = '0;

      // Held reset ignores load/enable across edges.
      rst = 1'b1; enable = 1'b1; load = 1'b1; d = 4'd7; up = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         check("rst_held_q", 8'(q), 8'(0));
      end
      rst = 1'b0;
      step(1'b1, 1'b0, 1'b1, '0, "post_rst");

      // Mixed random traffic against the model.
      for (int i = 0; i < 24; i++) begin
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
              1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), "rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule : tb_tff_counter
